div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_restoring_step.sv | 27 ++
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, M-extension divide function codes and
// the divider state encoding. The decoder and div_unit both import these.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int DIV_FUNC_WIDTH = 2;

  localparam logic [DIV_FUNC_WIDTH-1:0] DIV_OP  = 2'b00;
  localparam logic [DIV_FUNC_WIDTH-1:0] DIVU_OP = 2'b01;
  localparam logic [DIV_FUNC_WIDTH-1:0] REM_OP  = 2'b10;
  localparam logic [DIV_FUNC_WIDTH-1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } div_state_t;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface div_unit_if;
  import riscv_pkg::*;

  logic                      start_div;
  logic [DIV_FUNC_WIDTH-1:0] div_func;
  logic [XLEN-1:0]           src_a;
  logic [XLEN-1:0]           src_b;
  logic                      flush;
  logic                      busy;
  logic                      done;
  logic [XLEN-1:0]           div_result;

  modport master (
    output start_div, div_func, src_a, src_b, flush,
    input  busy, done, div_result
  );

  modport slave (
    input  start_div, div_func, src_a, src_b, flush,
    output busy, done, div_result
  );

endinterface

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_restoring_step
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_shift;

  // quo_in holds the not-yet-consumed dividend bits, so its MSB feeds the remainder
  always_comb begin
    rem_shift = {rem_in, quo_in[XLEN-1]};
    if (rem_shift >= {1'b0, divisor}) begin
      rem_out = rem_shift[XLEN-1:0] - divisor;
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = rem_shift[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage; busy stalls the
// pipeline, done pulses for one cycle with the registered result.
module div_unit
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t                state_q, state_d;
  logic [5:0]                cnt_q, cnt_d;
  logic [DIV_FUNC_WIDTH-1:0] func_q, func_d;
  logic [XLEN-1:0]           quo_q, quo_d;
  logic [XLEN-1:0]           rem_q, rem_d;
  logic [XLEN-1:0]           divisor_q, divisor_d;
  logic                      q_neg_q, q_neg_d;
  logic                      r_neg_q, r_neg_d;
  logic [XLEN-1:0]           result_q, result_d;
  logic                      done_q, done_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic            signed_op;

  div_restoring_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign signed_op = ~bus.div_func[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_div && !bus.flush) begin
          func_d    = bus.div_func;
          cnt_d     = '0;
          rem_d     = '0;
          q_neg_d   = 1'b0;
          r_neg_d   = 1'b0;
          divisor_d = bus.src_b;
          // Special cases preload the final quotient/remainder and skip iteration
          if (bus.src_b == '0) begin
            quo_d   = '1;
            rem_d   = bus.src_a;
            state_d = FIN;
          end else if (signed_op && bus.src_a == INT_MIN && bus.src_b == '1) begin
            quo_d   = bus.src_a;
            state_d = FIN;
          end else if (signed_op) begin
            quo_d     = abs_val(bus.src_a);
            divisor_d = abs_val(bus.src_b);
            q_neg_d   = bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1];
            r_neg_d   = bus.src_a[XLEN-1];
            state_d   = CALC;
          end else begin
            quo_d   = bus.src_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          if (cnt_q == LAST_ITER) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (func_q[1]) result_d = r_neg_q ? twos_neg(rem_q) : rem_q;
          else           result_d = q_neg_q ? twos_neg(quo_q) : quo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      func_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results and latencies are queued at
// start and compared whenever done pulses.
module tb_div_unit;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          startCyc;
  } sbEntry_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  logic prevDone;
  logic [31:0] lastResult;
  sbEntry_t sbQ[$];

  div_unit_if bus();

  div_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelDiv(input logic [1:0] func, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return func[1] ? a : 32'hFFFF_FFFF;
    if (!func[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return func[1] ? 32'd0 : a;
    case (func)
      DIV_OP:  return 32'(sa / sb);
      REM_OP:  return 32'(sa % sb);
      DIVU_OP: return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int modelLat(input logic [1:0] func, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!func[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Caller sits on a negedge; start is sampled at the following posedge
  task automatic applyStimulus(input logic [1:0] func, input logic [31:0] a, input logic [31:0] b, input bit accept);
    sbEntry_t e;
    bus.start_div = 1'b1;
    bus.div_func  = func;
    bus.src_a     = a;
    bus.src_b     = b;
    if (accept) begin
      e.res      = modelDiv(func, a, b);
      e.lat      = modelLat(func, a, b);
      e.startCyc = cyc + 1;
      sbQ.push_back(e);
    end
    @(negedge clk);
    bus.start_div = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    sbEntry_t e;
    if (rst_n && bus.done) begin
      checkOutput("done_repeat", 32'(prevDone), 32'd0);
      checkOutput("busy_with_done", 32'(bus.busy), 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("result", bus.div_result, e.res);
        checkOutput("latency", 32'(cyc - e.startCyc), 32'(e.lat));
        lastResult = e.res;
      end
    end
    prevDone = bus.done;
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    cyc = 0;
    prevDone = 1'b0;
    lastResult = 32'd0;
    rst_n = 1'b0;
    bus.start_div = 1'b0;
    bus.div_func  = DIV_OP;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.flush     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_result", bus.div_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // divu 100/7 with busy-length check, then remu back-to-back in the done cycle
    applyStimulus(DIVU_OP, 32'd100, 32'd7, 1'b1);
    n = 0;
    for (int i = 0; i < 100 && bus.busy; i++) begin
      n++;
      @(negedge clk);
    end
    checkOutput("divu_busy_cycles", 32'(n), 32'd33);
    checkOutput("divu_done_after_busy", 32'(bus.done), 32'd1);
    applyStimulus(REMU_OP, 32'd100, 32'd7, 1'b1);
    waitDone("remu");
    @(negedge clk);

    // signed sign-fixup and special-case table
    applyStimulus(DIV_OP,  32'hFFFF_FFF9, 32'd2,         1'b1); waitDone("div_neg");
    applyStimulus(REM_OP,  32'hFFFF_FFF9, 32'd2,         1'b1); waitDone("rem_neg");
    applyStimulus(REM_OP,  32'd7,         32'hFFFF_FFFE, 1'b1); waitDone("rem_negdiv");
    applyStimulus(DIVU_OP, 32'hFFFF_FFF9, 32'd2,         1'b1); waitDone("divu_big");
    applyStimulus(DIV_OP,  32'd5,         32'd0,         1'b1); waitDone("div_by0");
    applyStimulus(REM_OP,  32'd5,         32'd0,         1'b1); waitDone("rem_by0");
    applyStimulus(DIVU_OP, 32'd0,         32'd0,         1'b1); waitDone("divu_0by0");
    applyStimulus(DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDone("div_ovf");
    applyStimulus(REM_OP,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDone("rem_ovf");
    applyStimulus(DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDone("divu_ovf");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i), $urandom, $urandom_range(1, 1000), 1'b1);
      waitDone("random");
    end
    @(negedge clk);

    // flush mid-CALC: no done, result held
    applyStimulus(DIVU_OP, 32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    void'(sbQ.pop_front());
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy", 32'(bus.busy), 32'd0);
    checkOutput("flush_done", 32'(bus.done), 32'd0);
    checkOutput("flush_result_held", bus.div_result, lastResult);
    repeat (40) @(negedge clk);
    checkOutput("flush_result_still", bus.div_result, lastResult);

    // flush and start together in IDLE: nothing begins
    bus.flush = 1'b1;
    applyStimulus(DIV_OP, 32'd9, 32'd3, 1'b0);
    bus.flush = 1'b0;
    checkOutput("flush_start_busy", 32'(bus.busy), 32'd0);

    // start pulsed while busy is ignored; next op starts in the done cycle
    applyStimulus(DIVU_OP, 32'd1000, 32'd10, 1'b1);
    repeat (5) @(negedge clk);
    applyStimulus(DIVU_OP, 32'd9, 32'd3, 1'b0);
    waitDone("ignore_first");
    applyStimulus(DIV_OP, 32'hFFFF_FF9C, 32'd7, 1'b1);
    waitDone("b2b");
    repeat (40) @(negedge clk);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

    // reset during CALC drops the op and clears the result
    applyStimulus(DIVU_OP, 32'd100, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sbQ.delete();
    @(negedge clk);
    checkOutput("rst_calc_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_calc_done", 32'(bus.done), 32'd0);
    checkOutput("rst_calc_result", bus.div_result, 32'd0);
    rst_n = 1'b1;
    lastResult = 32'd0;
    @(negedge clk);
    applyStimulus(REMU_OP, 32'd100, 32'd7, 1'b1);
    waitDone("after_reset");
    repeat (3) @(negedge clk);
    checkOutput("final_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
